// File: rtl/game_pkg.sv
// Shared game constants and the move scheduler state encoding.
package game_pkg;

  // Entity IDs: ghosts first so they resolve before Pac-Man in a sweep.
  localparam logic [2:0] GHOST0   = 3'd0;
  localparam logic [2:0] GHOST1   = 3'd1;
  localparam logic [2:0] GHOST2   = 3'd2;
  localparam logic [2:0] GHOST3   = 3'd3;
  localparam logic [2:0] PAC_ID   = 3'd4;
  localparam logic [2:0] SEL_NONE = 3'd7;

  // Maze extent; coordinates at or beyond these are outside the maze.
  localparam int MAZE_W = 28;
  localparam int MAZE_H = 31;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    SELECT,
    LOOKUP,
    WAIT,
    COMMIT,
    DONE
  } sched_state_t;

  // True when (x, y) addresses a real maze cell.
  function automatic logic in_maze(input logic [4:0] x, input logic [4:0] y);
    return (int'(x) < MAZE_W) && (int'(y) < MAZE_H);
  endfunction

endpackage

// File: rtl/move_scheduler.sv
// Per-step sequencer: walks the enabled entities in ascending ID order,
// does one wall lookup per entity through the shared maze port and
// broadcasts a blocked/clear commit for each.
module move_scheduler
  import game_pkg::*;
#(
  parameter int NUM_ENT  = 5,
  parameter int MAZE_LAT = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               tick,
  input  logic [NUM_ENT-1:0] ent_en,
  input  logic [4:0]         req_x,
  input  logic [4:0]         req_y,
  output logic [2:0]         select,
  output logic               maze_rd,
  output logic [4:0]         maze_x,
  output logic [4:0]         maze_y,
  input  logic               maze_wall,
  output logic               commit,
  output logic [2:0]         commit_id,
  output logic [4:0]         commit_x,
  output logic [4:0]         commit_y,
  output logic               blocked,
  output logic               busy,
  output logic               done,
  output logic [7:0]         overrun_cnt
);

  // idx must be able to hold NUM_ENT itself, which marks the end of a sweep.
  localparam int               IDX_W    = $clog2(NUM_ENT + 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_ENT);
  localparam logic [2:0]       LAT_LOAD = 3'(MAZE_LAT);

  sched_state_t       state_q;
  logic [NUM_ENT-1:0] mask_q;
  logic [IDX_W-1:0]   idx_q;
  logic [4:0]         cap_x_q;
  logic [4:0]         cap_y_q;
  logic               oob_q;
  logic [2:0]         wait_q;
  logic [2:0]         select_q;
  logic               maze_rd_q;
  logic [4:0]         maze_x_q;
  logic [4:0]         maze_y_q;
  logic               commit_q;
  logic [2:0]         commit_id_q;
  logic [4:0]         commit_x_q;
  logic [4:0]         commit_y_q;
  logic               blocked_q;
  logic               busy_q;
  logic               done_q;
  logic [7:0]         overrun_q;

  // Sweep FSM. Every output is a register, so each strobe is loaded on the
  // edge that enters the state it belongs to: maze_rd is loaded leaving
  // SELECT (visible in LOOKUP), commit is loaded leaving LOOKUP/WAIT
  // (visible in COMMIT), done is loaded leaving the final SCAN.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      mask_q      <= '0;
      idx_q       <= '0;
      cap_x_q     <= '0;
      cap_y_q     <= '0;
      oob_q       <= 1'b0;
      wait_q      <= '0;
      select_q    <= SEL_NONE;
      maze_rd_q   <= 1'b0;
      maze_x_q    <= '0;
      maze_y_q    <= '0;
      commit_q    <= 1'b0;
      commit_id_q <= '0;
      commit_x_q  <= '0;
      commit_y_q  <= '0;
      blocked_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      maze_rd_q <= 1'b0;
      commit_q  <= 1'b0;
      done_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            mask_q  <= ent_en;
            idx_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (idx_q == LAST_IDX) begin
            done_q   <= 1'b1;
            select_q <= SEL_NONE;
            state_q  <= DONE;
          end else if (mask_q[idx_q]) begin
            select_q <= 3'(idx_q);
            state_q  <= SELECT;
          end else begin
            idx_q <= idx_q + IDX_W'(1);
          end
        end
        SELECT: begin
          // The move logic presents its request during this cycle, so the
          // range check and lookup address come straight from req_x/req_y.
          cap_x_q <= req_x;
          cap_y_q <= req_y;
          if (in_maze(req_x, req_y)) begin
            maze_rd_q <= 1'b1;
            maze_x_q  <= req_x;
            maze_y_q  <= req_y;
            oob_q     <= 1'b0;
          end else begin
            oob_q <= 1'b1;
          end
          state_q <= LOOKUP;
        end
        LOOKUP: begin
          if (oob_q) begin
            commit_q    <= 1'b1;
            commit_id_q <= 3'(idx_q);
            commit_x_q  <= cap_x_q;
            commit_y_q  <= cap_y_q;
            blocked_q   <= 1'b1;
            state_q     <= COMMIT;
          end else begin
            wait_q  <= LAT_LOAD;
            state_q <= WAIT;
          end
        end
        WAIT: begin
          if (wait_q == 3'd1) begin
            // Last wait cycle: maze_wall is valid now and goes straight
            // into the verdict register.
            commit_q    <= 1'b1;
            commit_id_q <= 3'(idx_q);
            commit_x_q  <= cap_x_q;
            commit_y_q  <= cap_y_q;
            blocked_q   <= maze_wall;
            state_q     <= COMMIT;
          end else begin
            wait_q <= wait_q - 3'd1;
          end
        end
        COMMIT: begin
          oob_q   <= 1'b0;
          idx_q   <= idx_q + IDX_W'(1);
          state_q <= SCAN;
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  // Count ticks that arrive while a sweep is running, saturating at 255.
  always_ff @(posedge clock) begin
    if (reset) begin
      overrun_q <= '0;
    end else if (tick && busy_q && (overrun_q != 8'hFF)) begin
      overrun_q <= overrun_q + 8'd1;
    end
  end

  assign select      = select_q;
  assign maze_rd     = maze_rd_q;
  assign maze_x      = maze_x_q;
  assign maze_y      = maze_y_q;
  assign commit      = commit_q;
  assign commit_id   = commit_id_q;
  assign commit_x    = commit_x_q;
  assign commit_y    = commit_y_q;
  assign blocked     = blocked_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign overrun_cnt = overrun_q;

endmodule

// File: tb/tb_move_scheduler.sv
// Directed bench for move_scheduler with a commit scoreboard and a
// latency-accurate maze memory model.
module tb_move_scheduler;
  import game_pkg::*;

  localparam int NE  = 5;
  localparam int LAT = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic          tick;
  logic [NE-1:0] ent_en;
  logic [4:0]    req_x;
  logic [4:0]    req_y;
  logic [2:0]    select;
  logic          maze_rd;
  logic [4:0]    maze_x;
  logic [4:0]    maze_y;
  logic          maze_wall;
  logic          commit;
  logic [2:0]    commit_id;
  logic [4:0]    commit_x;
  logic [4:0]    commit_y;
  logic          blocked;
  logic          busy;
  logic          done;
  logic [7:0]    overrun_cnt;

  int errors = 0;
  int checks = 0;

  always #5 clock = ~clock;

  move_scheduler #(.NUM_ENT(NE), .MAZE_LAT(LAT)) dut (
    .clock       (clock),
    .reset       (reset),
    .tick        (tick),
    .ent_en      (ent_en),
    .req_x       (req_x),
    .req_y       (req_y),
    .select      (select),
    .maze_rd     (maze_rd),
    .maze_x      (maze_x),
    .maze_y      (maze_y),
    .maze_wall   (maze_wall),
    .commit      (commit),
    .commit_id   (commit_id),
    .commit_x    (commit_x),
    .commit_y    (commit_y),
    .blocked     (blocked),
    .busy        (busy),
    .done        (done),
    .overrun_cnt (overrun_cnt)
  );

  // Per-entity requested coordinates (the move logic stand-in).
  logic [4:0] tx [NE];
  logic [4:0] ty [NE];

  always_comb begin
    req_x = 5'd0;
    req_y = 5'd0;
    if (select < 3'(NE)) begin
      req_x = tx[select];
      req_y = ty[select];
    end
  end

  // Maze memory: a single configurable wall cell, answered LAT cycles after
  // maze_rd; outside that one cycle the data line carries the opposite value.
  logic       wall_on;
  logic [4:0] wall_x;
  logic [4:0] wall_y;
  logic       rd_d1 = 1'b0, rd_d2 = 1'b0, w_d1 = 1'b0, w_d2 = 1'b0;

  function automatic logic wall_at(input logic [4:0] x, input logic [4:0] y);
    return wall_on && (x == wall_x) && (y == wall_y);
  endfunction

  always @(posedge clock) begin
    rd_d1 <= maze_rd;
    w_d1  <= wall_at(maze_x, maze_y);
    rd_d2 <= rd_d1;
    w_d2  <= w_d1;
  end

  assign maze_wall = rd_d2 ? w_d2 : ~w_d2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected commits, in the order they must appear.
  typedef struct packed {
    logic [2:0] id;
    logic [4:0] x;
    logic [4:0] y;
    logic       oob;
    logic       blk;
  } exp_t;

  exp_t sb [$];
  exp_t cur;

  task automatic push_sweep(input logic [NE-1:0] en);
    exp_t e;
    for (int i = 0; i < NE; i++) begin
      if (en[i]) begin
        e.id  = 3'(i);
        e.x   = tx[i];
        e.y   = ty[i];
        e.oob = (tx[i] >= 5'd28) || (ty[i] >= 5'd31);
        e.blk = e.oob || wall_at(tx[i], ty[i]);
        sb.push_back(e);
      end
    end
  endtask

  // Busy length of a sweep: 4+LAT per in-range entity, 4 per out-of-range,
  // 1 per disabled, plus the final scan and the done cycle.
  function automatic int sweep_cycles(input logic [NE-1:0] en);
    int n = 2;
    for (int i = 0; i < NE; i++) begin
      if (en[i]) n += ((tx[i] >= 5'd28) || (ty[i] >= 5'd31)) ? 4 : 4 + LAT;
      else n += 1;
    end
    return n;
  endfunction

  // Compare every commit and lookup against the scoreboard head.
  always @(negedge clock) begin
    if (commit) begin
      chk("commit_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        cur = sb.pop_front();
        chk("commit_id", 32'(commit_id), 32'(cur.id));
        chk("commit_x", 32'(commit_x), 32'(cur.x));
        chk("commit_y", 32'(commit_y), 32'(cur.y));
        chk($sformatf("blocked_id%0d", cur.id), 32'(blocked), 32'(cur.blk));
        $display("commit id=%0d x=%0d y=%0d blocked=%0d", commit_id, commit_x, commit_y, blocked);
      end
    end
    if (maze_rd) begin
      chk("rd_pending", 32'(sb.size() > 0), 32'd1);
      if (sb.size() > 0) begin
        chk("rd_x", 32'(maze_x), 32'(sb[0].x));
        chk("rd_y", 32'(maze_y), 32'(sb[0].y));
        chk($sformatf("rd_inrange_id%0d", sb[0].id), 32'(sb[0].oob), 32'd0);
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One accepted tick, then wait (bounded) for done and check sweep length.
  task automatic run_sweep(input string tag, input logic [NE-1:0] en);
    int n;
    int exp_len;
    exp_len = sweep_cycles(en);
    ent_en  = en;
    push_sweep(en);
    tick = 1'b1;
    step();
    tick   = 1'b0;
    ent_en = ~en;
    chk({tag, "_busy_rise"}, 32'(busy), 32'd1);
    n = 0;
    while (!done && n < 200) begin
      step();
      n++;
    end
    chk({tag, "_done_cycle"}, 32'(n), 32'(exp_len - 1));
    step();
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
    chk({tag, "_drained"}, 32'(sb.size()), 32'd0);
    $display("sweep %s en=%b done_at=%0d", tag, en, n);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int ov_exp;
    int exp_len;

    tx = '{5'd3, 5'd7, 5'd12, 5'd20, 5'd5};
    ty = '{5'd1, 5'd4, 5'd22, 5'd29, 5'd10};
    wall_on = 1'b0;
    wall_x  = 5'd0;
    wall_y  = 5'd0;
    reset   = 1'b1;
    tick    = 1'b0;
    ent_en  = '0;
    repeat (3) step();

    // Reset values.
    chk("rst_select", 32'(select), 32'd7);
    chk("rst_maze_rd", 32'(maze_rd), 32'd0);
    chk("rst_commit", 32'(commit), 32'd0);
    chk("rst_blocked", 32'(blocked), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_maze_xy", 32'({maze_x, maze_y}), 32'd0);
    chk("rst_commit_fields", 32'({commit_id, commit_x, commit_y}), 32'd0);
    chk("rst_overrun", 32'(overrun_cnt), 32'd0);
    reset = 1'b0;
    step();

    // Only Pac-Man, (5,10), no wall: cycle-exact timeline from acceptance.
    ent_en = 5'b10000;
    push_sweep(ent_en);
    tick = 1'b1;
    step();
    tick = 1'b0;
    for (int c = 0; c <= 12; c++) begin
      chk($sformatf("s1_select_c%0d", c), 32'(select), (c >= 5 && c <= 10) ? 32'd4 : 32'd7);
      chk($sformatf("s1_maze_rd_c%0d", c), 32'(maze_rd), 32'(c == 6));
      chk($sformatf("s1_commit_c%0d", c), 32'(commit), 32'(c == 9));
      chk($sformatf("s1_done_c%0d", c), 32'(done), 32'(c == 11));
      chk($sformatf("s1_busy_c%0d", c), 32'(busy), 32'(c <= 11));
      step();
    end
    chk("s1_drained", 32'(sb.size()), 32'd0);

    // All enabled, wall under ghost 2 only; done in cycle 31 (32nd busy cycle).
    wall_on = 1'b1;
    wall_x  = tx[2];
    wall_y  = ty[2];
    run_sweep("all_wall_g2", 5'b11111);

    // Pac-Man y underflow: blocked with no lookup.
    ty[4] = 5'd31;
    run_sweep("pac_y31", 5'b11111);

    // Sparse enable with edge coordinates: (27,30) in range and walled,
    // x=28 out of range, Pac-Man holding position on a clear cell.
    tx[0] = 5'd27; ty[0] = 5'd30;
    tx[2] = 5'd28;
    ty[4] = 5'd10;
    wall_x = 5'd27;
    wall_y = 5'd30;
    run_sweep("sparse_10101", 5'b10101);

    // Overrun: three ticks mid-sweep, one on the done cycle, and an
    // ent_en change that must not alter the sweep.
    ent_en  = 5'b11111;
    exp_len = sweep_cycles(ent_en);
    push_sweep(ent_en);
    tick = 1'b1;
    step();
    tick = 1'b0;
    n = 0;
    while (!done && n < 200) begin
      if (n == 2) ent_en = 5'b00000;
      tick = (n == 3) || (n == 10) || (n == 20);
      step();
      n++;
    end
    chk("ovr_done_cycle", 32'(n), 32'(exp_len - 1));
    tick = 1'b1;
    step();
    tick = 1'b0;
    chk("ovr_busy_fall", 32'(busy), 32'd0);
    chk("ovr_count4", 32'(overrun_cnt), 32'd4);
    chk("ovr_drained", 32'(sb.size()), 32'd0);
    $display("overrun after disturbed sweep = %0d", overrun_cnt);

    // Empty sweeps with tick held high through busy: 7 overruns each,
    // pushing the total past 300 into saturation.
    ov_exp = 4;
    for (int k = 0; k < 45; k++) begin
      ent_en = '0;
      tick   = 1'b1;
      step();
      n = 0;
      while (busy && n < 50) begin
        step();
        n++;
      end
      tick = 1'b0;
      ov_exp = (ov_exp + NE + 2 > 255) ? 255 : ov_exp + NE + 2;
      chk($sformatf("empty_len_k%0d", k), 32'(n), 32'(NE + 2));
      chk($sformatf("ov_sat_k%0d", k), 32'(overrun_cnt), 32'(ov_exp));
    end
    $display("overrun after saturation run = %0d", overrun_cnt);

    // Reset during ghost 1's lookup wait, with a tick in the reset cycle.
    tx[0] = 5'd3; ty[0] = 5'd1;
    tx[2] = 5'd12;
    ent_en = 5'b11111;
    push_sweep(ent_en);
    tick = 1'b1;
    step();
    tick = 1'b0;
    repeat (9) step();
    chk("pre_reset_select", 32'(select), 32'd1);
    reset = 1'b1;
    tick  = 1'b1;
    step();
    sb.delete();
    reset = 1'b0;
    tick  = 1'b0;
    chk("mid_rst_select", 32'(select), 32'd7);
    chk("mid_rst_commit", 32'(commit), 32'd0);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_maze_rd", 32'(maze_rd), 32'd0);
    chk("mid_rst_overrun", 32'(overrun_cnt), 32'd0);
    for (int c = 0; c < 6; c++) begin
      step();
      chk($sformatf("post_rst_quiet_c%0d", c), 32'({busy, commit, done}), 32'd0);
    end
    run_sweep("after_reset", 5'b11111);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
